// File: rtl/even_parity_serializer.sv
// Re-checks even parity on each accepted codeword; good codewords are sent as a
// start/data/parity/stop serial frame, bad ones are dropped and counted.
module even_parity_serializer #(
  parameter int DATA_W       = 3,
  parameter int CLKS_PER_BIT = 4,
  parameter int ERR_CNT_W    = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATA_W:0]      in_code,
  output logic                 tx,
  output logic                 busy,
  output logic                 done,
  output logic                 err_pulse,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam int TW = $clog2(CLKS_PER_BIT + 1);
  localparam int BW = $clog2(DATA_W + 1);
  localparam logic [TW-1:0] LAST_TICK = TW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_W);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t                 state, state_d;
  logic [TW-1:0]          timer, timer_d;
  logic [BW-1:0]          bit_cnt, bit_cnt_d;
  logic [DATA_W:0]        shreg, shreg_d;
  logic                   tx_d, busy_d, done_d, err_d;
  logic [ERR_CNT_W-1:0]   cnt_d;
  logic                   last_tick;

  assign in_ready  = (state == IDLE);
  assign last_tick = (timer == LAST_TICK);

  always_comb begin
    state_d   = state;
    timer_d   = timer;
    bit_cnt_d = bit_cnt;
    shreg_d   = shreg;
    err_d     = 1'b0;
    cnt_d     = err_count;
    unique case (state)
      IDLE: begin
        if (in_valid) begin
          if (^in_code) begin
            err_d = 1'b1;
            if (err_count != '1) cnt_d = err_count + ERR_CNT_W'(1);
          end else begin
            shreg_d = in_code;
            timer_d = '0;
            state_d = START;
          end
        end
      end
      START: begin
        if (last_tick) begin
          timer_d   = '0;
          bit_cnt_d = '0;
          state_d   = DATA;
        end else begin
          timer_d = timer + TW'(1);
        end
      end
      DATA: begin
        if (last_tick) begin
          timer_d = '0;
          shreg_d = shreg >> 1;
          if (bit_cnt == LAST_BIT) state_d = STOP;
          else                     bit_cnt_d = bit_cnt + BW'(1);
        end else begin
          timer_d = timer + TW'(1);
        end
      end
      STOP: begin
        if (last_tick) begin
          timer_d = '0;
          state_d = IDLE;
        end else begin
          timer_d = timer + TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered, so they are decoded from the next-state values.
    tx_d   = 1'b1;
    if (state_d == START)     tx_d = 1'b0;
    else if (state_d == DATA) tx_d = shreg_d[0];
    busy_d = (state_d != IDLE);
    done_d = (state_d == STOP) && (timer_d == LAST_TICK);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      timer     <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      tx        <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      err_pulse <= 1'b0;
      err_count <= '0;
    end else begin
      state     <= state_d;
      timer     <= timer_d;
      bit_cnt   <= bit_cnt_d;
      shreg     <= shreg_d;
      tx        <= tx_d;
      busy      <= busy_d;
      done      <= done_d;
      err_pulse <= err_d;
      err_count <= cnt_d;
    end
  end

endmodule

// File: tb/tb_even_parity_serializer.sv
// Bench for even_parity_serializer: frame-level model checked every cycle plus
// directed literal expectations.
module tb_even_parity_serializer;

  localparam int DW  = 3;
  localparam int CPB = 4;
  localparam int EW  = 8;
  localparam int FL  = (DW + 3) * CPB;
  localparam int CNT_MAX = (1 << EW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW:0]   in_code = '0;
  logic          tx, busy, done, err_pulse;
  logic [EW-1:0] err_count;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  even_parity_serializer #(.DATA_W(DW), .CLKS_PER_BIT(CPB), .ERR_CNT_W(EW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_code(in_code), .tx(tx), .busy(busy), .done(done),
    .err_pulse(err_pulse), .err_count(err_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: a frame is a precomputed waveform; m_pos is the cycle index into it.
  int   m_pos = -1;
  int   m_cnt = 0;
  logic m_err = 1'b0;
  logic m_wave [FL];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pos = -1;
      m_cnt = 0;
      m_err = 1'b0;
    end else begin
      m_err = 1'b0;
      if (m_pos < 0) begin
        if (in_valid) begin
          if (^in_code) begin
            m_err = 1'b1;
            if (m_cnt < CNT_MAX) m_cnt++;
          end else begin
            for (int i = 0; i < FL; i++) begin
              int b;
              b = i / CPB;
              if (b == 0)           m_wave[i] = 1'b0;
              else if (b <= DW + 1) m_wave[i] = in_code[b-1];
              else                  m_wave[i] = 1'b1;
            end
            m_pos = 0;
          end
        end
      end else begin
        m_pos++;
        if (m_pos == FL) m_pos = -1;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("tx",        tx,        (m_pos < 0) ? 1'b1 : m_wave[m_pos]);
      chk("busy",      busy,      m_pos >= 0);
      chk("done",      done,      m_pos == FL - 1);
      chk("in_ready",  in_ready,  m_pos < 0);
      chk("err_pulse", err_pulse, m_err);
      chk("err_count", err_count, m_cnt);
    end
    if (done) done_cnt++;
  end

  // Called at a negedge; returns at the negedge right after the accepting edge.
  task automatic send(input logic [DW:0] code);
    int n;
    in_valid = 1'b1;
    in_code  = code;
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("send_timeout", 0, 1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  logic s_tx [1:FL];
  logic s_dn [1:FL];
  int   k;
  int   done_before;
  logic [2:0] dv;

  initial begin
    #100000;
    errors++;
    $display("FAIL global_timeout");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_tx", tx, 1);
    chk("rst_busy", busy, 0);
    chk("rst_err_count", err_count, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);

    // Good codeword 0011: 0,1,1,0,0,1 with done only on the last stop cycle.
    send(4'b0011);
    for (int i = 1; i <= FL; i++) begin
      s_tx[i] = tx;
      s_dn[i] = done;
      @(negedge clk);
    end
    chk("good_in_ready_T25", in_ready, 1);
    begin
      logic [5:0] pat;
      int nd;
      pat = 6'b100110;
      nd = 0;
      for (int i = 1; i <= FL; i++) begin
        chk("good_tx_seq", s_tx[i], pat[(i-1)/CPB]);
        if (s_dn[i]) nd++;
      end
      chk("good_done_T24", s_dn[FL], 1);
      chk("good_done_once", nd, 1);
    end

    // Bad codeword
    send(4'b1011);
    chk("bad_err_pulse", err_pulse, 1);
    chk("bad_err_count", err_count, 1);
    chk("bad_tx", tx, 1);
    chk("bad_busy", busy, 0);
    @(negedge clk);
    chk("bad_err_pulse_off", err_pulse, 0);

    // Backpressure: bad codeword held during a frame
    send(4'b0101);
    in_valid = 1'b1;
    in_code  = 4'b1000;
    k = 1;
    while (!in_ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("bp_accept_cycle", k, FL + 1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp_err_pulse", err_pulse, 1);
    chk("bp_err_count", err_count, 2);

    // Saturation
    in_valid = 1'b1;
    in_code  = 4'b1000;
    repeat (300) @(negedge clk);
    in_valid = 1'b0;
    chk("sat_err_count", err_count, 8'hFF);
    chk("sat_err_pulse", err_pulse, 1);
    @(negedge clk);

    // All good codewords back-to-back
    done_before = done_cnt;
    for (int d = 0; d < 8; d++) begin
      dv = d[2:0];
      send({^dv, dv});
      for (int i = 1; i <= FL; i++) begin
        s_tx[i] = tx;
        @(negedge clk);
      end
      chk("frame_data", {s_tx[14], s_tx[10], s_tx[6]}, dv);
      chk("frame_parity", s_tx[18], ^dv);
      chk("frame_start", s_tx[2], 0);
      chk("frame_stop", s_tx[22], 1);
    end
    chk("done_pulses", done_cnt - done_before, 8);

    // Async reset mid-frame
    send(4'b0011);
    repeat (10) @(negedge clk);
    done_before = done_cnt;
    #3 rst_n = 1'b0;
    #1;
    chk("arst_tx", tx, 1);
    chk("arst_busy", busy, 0);
    chk("arst_in_ready", in_ready, 1);
    chk("arst_err_count", err_count, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    chk("arst_no_done", done_cnt - done_before, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
